// File: rtl/window_read_pkg.sv
// Shared types and default geometry for the windowed ring-buffer read controller.
// Widths are derived from the default geometry.
package window_read_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_VALID = 2'd1,
    S_FLUSH = 2'd2
  } wr_state_t;

  localparam int SIZE_DEF       = 8;
  localparam int WRITE_SIZE_DEF = 2;
  localparam int READ_SIZE_DEF  = 2;
  localparam int STRIDE_DEF     = 1;
  localparam int DATA_WIDTH_DEF = 8;

  localparam int PTR_W_DEF  = $clog2(SIZE_DEF);
  localparam int CNT_W_DEF  = $clog2(SIZE_DEF + 1);
  localparam int PCNT_W_DEF = $clog2(WRITE_SIZE_DEF + 1);

endpackage

// File: rtl/window_read_ctrl_if.sv
// Bundle between the read controller, the external ring buffer/writer and the consumer.
// The master modport is the controller side; slave is the environment side.
interface window_read_ctrl_if
  import window_read_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int WRITE_SIZE = WRITE_SIZE_DEF,
  parameter int READ_SIZE  = READ_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int PTR_W  = $clog2(SIZE);
  localparam int CNT_W  = $clog2(SIZE + 1);
  localparam int PCNT_W = $clog2(WRITE_SIZE + 1);

  logic                                  push_en;
  logic [PCNT_W-1:0]                     push_cnt;
  logic                                  wr_ready;
  logic [PTR_W-1:0]                      write_addr;
  logic [PTR_W-1:0]                      read_addr;
  logic [READ_SIZE-1:0][DATA_WIDTH-1:0]  buf_data;
  logic [READ_SIZE-1:0][DATA_WIDTH-1:0]  out_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  flush;
  logic [CNT_W-1:0]                      count;
  logic                                  overflow;

  modport master (
    input  push_en, push_cnt, buf_data, out_ready, flush,
    output wr_ready, write_addr, read_addr, out_data, out_valid, count, overflow
  );

  modport slave (
    output push_en, push_cnt, buf_data, out_ready, flush,
    input  wr_ready, write_addr, read_addr, out_data, out_valid, count, overflow
  );

endinterface

// File: rtl/ring_pointer.sv
// Modular ring pointer: wraps naturally at 2**WIDTH, with a load path that
// takes priority over the add-N path.
module ring_pointer
  import window_read_pkg::*;
#(
  parameter int WIDTH = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_add,
  input  logic [WIDTH-1:0] i_add_val,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_add) begin
      r_ptr <= r_ptr + i_add_val;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/window_read_ctrl.sv
// Read-side controller for a multi-word ring buffer: owns both pointers and the
// occupancy count, and presents READ_SIZE-word windows advancing by STRIDE.
module window_read_ctrl
  import window_read_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int WRITE_SIZE = WRITE_SIZE_DEF,
  parameter int READ_SIZE  = READ_SIZE_DEF,
  parameter int STRIDE     = STRIDE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  window_read_ctrl_if.master  bus
);

  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE + 1);

  localparam logic [CNT_W:0]   SIZE_EXT  = (CNT_W + 1)'(SIZE);
  localparam logic [CNT_W-1:0] READ_C    = CNT_W'(READ_SIZE);
  localparam logic [CNT_W-1:0] STRIDE_C  = CNT_W'(STRIDE);
  localparam logic [CNT_W-1:0] FREE_LIM  = CNT_W'(SIZE - WRITE_SIZE);
  localparam logic [PTR_W-1:0] STRIDE_P  = PTR_W'(STRIDE);

  wr_state_t r_state;
  wr_state_t w_state_nxt;

  logic [CNT_W-1:0]                     r_count;
  logic [CNT_W-1:0]                     w_count_nxt;
  logic                                 r_overflow;
  logic [READ_SIZE-1:0][DATA_WIDTH-1:0] r_out_data;

  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_push_add;
  logic [CNT_W-1:0] w_pop_sub;
  logic             w_in_flush;
  logic             w_push_fit;
  logic             w_push_acc;
  logic             w_push_rej;
  logic             w_load;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;

  // Acceptance is judged against the registered count only, so a pop in the
  // same cycle never makes room for a push.
  assign w_cnt_sum  = {1'b0, r_count} + (CNT_W + 1)'(bus.push_cnt);
  assign w_push_fit = (w_cnt_sum <= SIZE_EXT);
  assign w_in_flush = (r_state == S_FLUSH);
  assign w_push_acc = bus.push_en && w_push_fit  && !bus.flush && !w_in_flush;
  assign w_push_rej = bus.push_en && !w_push_fit && !bus.flush && !w_in_flush;

  assign w_load = ((r_state == S_FILL) || ((r_state == S_VALID) && bus.out_ready))
                  && (r_count >= READ_C) && !bus.flush;

  assign w_push_add  = w_push_acc ? CNT_W'(bus.push_cnt) : '0;
  assign w_pop_sub   = w_load     ? STRIDE_C             : '0;
  assign w_count_nxt = r_count + w_push_add - w_pop_sub;

  ring_pointer #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_add      (w_push_acc),
    .i_add_val  (PTR_W'(bus.push_cnt)),
    .o_ptr      (w_wr_ptr)
  );

  // Flush realigns the read side onto the current write pointer; a push in
  // the same cycle was dropped, so the write pointer does not move.
  ring_pointer #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (bus.flush),
    .i_load_val (w_wr_ptr),
    .i_add      (w_load),
    .i_add_val  (STRIDE_P),
    .o_ptr      (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_FLUSH;
    end else begin
      case (r_state)
        S_FILL:  if (w_load) w_state_nxt = S_VALID;
        S_VALID: if (bus.out_ready) w_state_nxt = w_load ? S_VALID : S_FILL;
        S_FLUSH: w_state_nxt = S_FILL;
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (bus.flush) begin
        r_count <= '0;
      end else begin
        r_count <= w_count_nxt;
      end
      if (w_push_rej) begin
        r_overflow <= 1'b1;
      end
      if (w_load) begin
        r_out_data <= bus.buf_data;
      end
    end
  end

  assign bus.out_valid  = (r_state == S_VALID);
  assign bus.out_data   = r_out_data;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.write_addr = w_wr_ptr;
  assign bus.read_addr  = w_rd_ptr;
  assign bus.wr_ready   = (r_count <= FREE_LIM) && !w_in_flush;

endmodule

// File: tb/tb_window_read_ctrl.sv
// Scenario bench for window_read_ctrl: a behavioural ring buffer feeds buf_data and
// a queue of pushed words predicts every presented window.
module tb_window_read_ctrl;

  localparam int SIZE       = 8;
  localparam int WRITE_SIZE = 2;
  localparam int READ_SIZE  = 2;
  localparam int STRIDE     = 1;
  localparam int DATA_WIDTH = 8;
  localparam int PCNT_W     = $clog2(WRITE_SIZE + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  window_read_ctrl_if #(
    .SIZE(SIZE), .WRITE_SIZE(WRITE_SIZE), .READ_SIZE(READ_SIZE), .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  window_read_ctrl #(
    .SIZE(SIZE), .WRITE_SIZE(WRITE_SIZE), .READ_SIZE(READ_SIZE),
    .STRIDE(STRIDE), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_WIDTH-1:0] mem   [SIZE];
  logic [DATA_WIDTH-1:0] wdata [WRITE_SIZE];
  logic                  tb_commit = 1'b0;
  logic [DATA_WIDTH-1:0] exp_q [$];
  logic [DATA_WIDTH-1:0] val_seq = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  // Behavioural buffer: the writer stores data only for pushes it expects to land.
  always @(posedge clk) begin
    if (bus.push_en && tb_commit) begin
      for (int i = 0; i < WRITE_SIZE; i++)
        if (i < int'(bus.push_cnt)) mem[(int'(bus.write_addr) + i) % SIZE] <= wdata[i];
    end
  end

  always_comb begin
    for (int i = 0; i < READ_SIZE; i++)
      bus.buf_data[i] = mem[(int'(bus.read_addr) + i) % SIZE];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: scoreboard check at the falling edge, then settle past the rising edge.
  task automatic step();
    @(negedge clk);
    if (rst && bus.out_valid) begin
      if (exp_q.size() < READ_SIZE) begin
        n_checks++; n_fail++;
        $display("FAIL window_underrun: model holds %0d words, need %0d", exp_q.size(), READ_SIZE);
      end else begin
        for (int i = 0; i < READ_SIZE; i++) begin
          n_checks++;
          if (bus.out_data[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL window_word%0d: got %h expected %h", i, bus.out_data[i], exp_q[i]);
          end
        end
      end
      if (bus.out_ready) begin
        for (int s = 0; s < STRIDE; s++) if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input int cnt, input bit acc);
    bus.push_en  = (cnt > 0);
    bus.push_cnt = PCNT_W'(cnt);
    tb_commit    = acc;
    for (int i = 0; i < WRITE_SIZE; i++) wdata[i] = acc ? (val_seq + DATA_WIDTH'(i)) : 8'hEE;
    if (acc) begin
      for (int i = 0; i < cnt; i++) exp_q.push_back(val_seq + DATA_WIDTH'(i));
      val_seq = val_seq + DATA_WIDTH'(cnt);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.push_en   = 1'b0;
    bus.push_cnt  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tb_commit     = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    set_push(0, 0);
    for (int c = 0; c < 40; c++) begin
      if (!bus.out_valid && (int'(bus.count) < READ_SIZE)) break;
      step();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || int'(bus.count) >= READ_SIZE) begin
      n_fail++;
      $display("FAIL drain_timeout: out_valid=%0b count=%0d after cycle budget", bus.out_valid, bus.count);
    end
    n_checks++;
    if (int'(bus.count) !== exp_q.size()) begin
      n_fail++;
      $display("FAIL drain_count: got %0d expected %0d", bus.count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.write_addr !== 3'd0) begin n_fail++; $display("FAIL rst_write_addr: got %0d expected 0", bus.write_addr); end
    n_checks++; if (bus.read_addr !== 3'd0) begin n_fail++; $display("FAIL rst_read_addr: got %0d expected 0", bus.read_addr); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", bus.overflow); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %0b expected 1", bus.wr_ready); end
    n_checks++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0000", bus.out_data); end
  endtask

  task automatic test_first_window();
    int acc0;
    do_reset();
    acc0 = n_acc;
    bus.out_ready = 1'b1;
    val_seq = 8'hA0;
    set_push(2, 1);
    step();
    set_push(0, 0);
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL first_count2: got %0d expected 2", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL first_not_valid_yet: got %0b expected 0", bus.out_valid); end
    step();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %0b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_data[0] !== 8'hA0) begin n_fail++; $display("FAIL first_word0: got %h expected a0", bus.out_data[0]); end
    n_checks++; if (bus.out_data[1] !== 8'hA1) begin n_fail++; $display("FAIL first_word1: got %h expected a1", bus.out_data[1]); end
    n_checks++; if (bus.read_addr !== 3'd1) begin n_fail++; $display("FAIL first_read_addr: got %0d expected 1", bus.read_addr); end
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL first_count1: got %0d expected 1", bus.count); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL first_back_to_fill: got %0b expected 0", bus.out_valid); end
    n_checks++; if (n_acc - acc0 !== 1) begin n_fail++; $display("FAIL first_accepts: got %0d expected 1", n_acc - acc0); end
  endtask

  task automatic test_stream();
    int acc0;
    do_reset();
    acc0 = n_acc;
    val_seq = 8'h10;
    for (int n = 0; n < 10; n++) begin
      bus.out_ready = !(n >= 5 && n <= 7);
      set_push(1, 1);
      step();
    end
    drain();
    n_checks++; if (n_acc - acc0 !== 9) begin n_fail++; $display("FAIL stream_windows: got %0d expected 9", n_acc - acc0); end
    n_checks++; if (bus.read_addr !== 3'd1) begin n_fail++; $display("FAIL stream_read_wrap: got %0d expected 1", bus.read_addr); end
    n_checks++; if (bus.write_addr !== 3'd2) begin n_fail++; $display("FAIL stream_write_wrap: got %0d expected 2", bus.write_addr); end
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL stream_residue: got %0d expected 1", bus.count); end
  endtask

  task automatic test_overflow();
    do_reset();
    val_seq = 8'h40;
    for (int n = 0; n < 4; n++) begin
      set_push(2, 1);
      step();
    end
    set_push(1, 1);
    step();
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", bus.count); end
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %0b expected 0", bus.wr_ready); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_overflow_yet: got %0b expected 0", bus.overflow); end
    n_checks++; if (bus.write_addr !== 3'd1) begin n_fail++; $display("FAIL full_write_addr: got %0d expected 1", bus.write_addr); end
    set_push(2, 0);
    step();
    set_push(0, 0);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", bus.overflow); end
    n_checks++; if (bus.write_addr !== 3'd1) begin n_fail++; $display("FAIL ovf_write_addr: got %0d expected 1", bus.write_addr); end
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", bus.count); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.count !== 4'd7) begin n_fail++; $display("FAIL full_load_count: got %0d expected 7", bus.count); end
    n_checks++; if (bus.read_addr !== 3'd2) begin n_fail++; $display("FAIL full_load_read_addr: got %0d expected 2", bus.read_addr); end
    step();
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    val_seq = 8'h60;
    set_push(2, 1);
    step();
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL b2b_count2: got %0d expected 2", bus.count); end
    set_push(2, 1);
    step();
    n_checks++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL b2b_count3: got %0d expected 3", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0b expected 1", bus.out_valid); end
    set_push(2, 1);
    step();
    n_checks++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL b2b_push_and_load: got %0d expected 4", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_still_valid: got %0b expected 1", bus.out_valid); end
    drain();
  endtask

  task automatic test_flush();
    do_reset();
    val_seq = 8'h80;
    for (int n = 0; n < 3; n++) begin
      set_push(2, 1);
      step();
    end
    n_checks++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 5", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %0b expected 1", bus.out_valid); end
    bus.flush = 1'b1;
    set_push(2, 0);
    step();
    exp_q.delete();
    bus.flush = 1'b0;
    set_push(0, 0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.write_addr !== 3'd6) begin n_fail++; $display("FAIL flush_push_dropped: got %0d expected 6", bus.write_addr); end
    n_checks++; if (bus.read_addr !== 3'd6) begin n_fail++; $display("FAIL flush_read_addr: got %0d expected 6", bus.read_addr); end
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL flush_wr_ready: got %0b expected 0", bus.wr_ready); end
    step();
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_recover_ready: got %0b expected 1", bus.wr_ready); end
    bus.out_ready = 1'b1;
    val_seq = 8'h90;
    set_push(2, 1);
    step();
    set_push(0, 0);
    step();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_after_valid: got %0b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_data[0] !== 8'h90) begin n_fail++; $display("FAIL flush_after_word0: got %h expected 90", bus.out_data[0]); end
    n_checks++; if (bus.read_addr !== 3'd7) begin n_fail++; $display("FAIL flush_after_read_addr: got %0d expected 7", bus.read_addr); end
    drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    val_seq = 8'hC0;
    for (int n = 0; n < 3; n++) begin
      set_push(2, 1);
      step();
    end
    set_push(0, 0);
    n_checks++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL areset_pre_count: got %0d expected 5", bus.count); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.write_addr !== 3'd0) begin n_fail++; $display("FAIL areset_write_addr: got %0d expected 0", bus.write_addr); end
    n_checks++; if (bus.read_addr !== 3'd0) begin n_fail++; $display("FAIL areset_read_addr: got %0d expected 0", bus.read_addr); end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.push_en   = 1'b0;
    bus.push_cnt  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_first_window();
    test_stream();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
